sdram_frame_buf_ctrl: RTL

Parametrised successor to the SDRAM FIFO-port controller. It generates burst addresses and read/write requests for an N-buffer frame ring (2–4 buffers), or for a linear region when ring mode is off. It sits between the write/read port FIFOs (their fill levels arrive as inputs) and the SDRAM command controller. Beyond the previous block, it adds deterministic buffer selection, a frame-drop/repeat report, request hold-until-ack, and read starvation protection.

---
 rtl/sdram_fb_pkg.sv | 13 +
 rtl/sdram_frame_buf_ctrl_if.sv | 13 +
 rtl/sdram_buf_ring.sv | 65 ++++++
 rtl/sdram_frame_buf_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/sdram_fb_pkg.sv
// sdram_fb_pkg: shared widths, buffer index type, grant encoding and free-buffer search
package sdram_fb_pkg;
  localparam int ADDR_W_DEF = 24;
  localparam int LEN_W_DEF = 10;
  typedef logic [1:0] buf_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;
  // returns {found, idx}: lowest index below num that is neither cur nor rd
  function automatic logic [2:0] next_free(buf_t cur, buf_t rd, int num);
    next_free = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (i < num && buf_t'(i) != cur && buf_t'(i) != rd) next_free = {1'b1, buf_t'(i)};
  endfunction
endpackage

// File: rtl/sdram_frame_buf_ctrl_if.sv
// sdram_frame_buf_ctrl_if: burst request/ack/address handshake toward the SDRAM command controller
interface sdram_frame_buf_ctrl_if import sdram_fb_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
  logic [ADDR_W-1:0] sdram_wr_addr, sdram_rd_addr;
  modport master (
    output sdram_wr_req, sdram_wr_addr, sdram_rd_req, sdram_rd_addr,
    input sdram_wr_ack, sdram_rd_ack
  );
  modport slave (
    input sdram_wr_req, sdram_wr_addr, sdram_rd_req, sdram_rd_addr,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_buf_ring.sv
// sdram_buf_ring: writer/reader buffer selection over the frame ring with drop/repeat reporting
module sdram_buf_ring import sdram_fb_pkg::*; #(
  parameter int NUM_BUF = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_load_i,
  input  logic rd_load_i,
  input  logic wr_cmp_i,
  input  logic rd_cmp_i,
  output buf_t wr_buf_o,
  output buf_t rd_buf_o,
  output logic frame_drop_o,
  output logic frame_repeat_o
);
  buf_t wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, last_q, last_d;
  logic dv_q, dv_d, drop_q, drop_d, rep_q, rep_d;
  logic [2:0] nf;
  // reader resolves first so the writer avoids the buffer the reader is moving onto
  always_comb begin
    rd_buf_d = rd_buf_q;
    wr_buf_d = wr_buf_q;
    last_d = last_q;
    dv_d = dv_q;
    drop_d = 1'b0;
    rep_d = 1'b0;
    if (rd_load_i) rd_buf_d = dv_q ? last_q : rd_buf_q;
    else if (rd_cmp_i) begin
      rd_buf_d = dv_q && last_q != rd_buf_q ? last_q : rd_buf_q;
      dv_d = dv_q && last_q == rd_buf_q;
      rep_d = !(dv_q && last_q != rd_buf_q);
    end
    nf = next_free(wr_buf_q, rd_buf_d, NUM_BUF);
    if (wr_load_i) begin
      wr_buf_d = '0;
      dv_d = 1'b0;
    end else if (wr_cmp_i) begin
      last_d = wr_buf_q;
      dv_d = 1'b1;
      wr_buf_d = nf[2] ? nf[1:0] : wr_buf_q;
      drop_d = ~nf[2];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_buf_q <= '0;
      rd_buf_q <= '0;
      last_q <= '0;
      dv_q <= 1'b0;
      drop_q <= 1'b0;
      rep_q <= 1'b0;
    end else begin
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
      last_q <= last_d;
      dv_q <= dv_d;
      drop_q <= drop_d;
      rep_q <= rep_d;
    end
  end
  assign wr_buf_o = wr_buf_q;
  assign rd_buf_o = rd_buf_q;
  assign frame_drop_o = drop_q;
  assign frame_repeat_o = rep_q;
endmodule

// File: rtl/sdram_frame_buf_ctrl.sv
// sdram_frame_buf_ctrl: burst address generation and write/read request arbitration for a frame ring
module sdram_frame_buf_ctrl import sdram_fb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int NUM_BUF = 3,
  parameter int BUF_SHIFT = 20,
  parameter int STARVE_MAX = 4
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic init_done,
  input  logic ring_en,
  input  logic wr_load,
  input  logic rd_load,
  input  logic read_valid,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic [LEN_W-1:0] wr_length,
  input  logic [LEN_W-1:0] rd_length,
  input  logic [LEN_W-1:0] wrf_use,
  input  logic [LEN_W-1:0] rdf_use,
  output logic [1:0] wr_buf_idx,
  output logic [1:0] rd_buf_idx,
  output logic frame_drop,
  output logic frame_repeat,
  sdram_frame_buf_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << BUF_SHIFT) - 64'd1);
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  logic [ADDR_W-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic wr_ack_q, rd_ack_q, wr_load_q, rd_load_q;
  logic wr_own_q, wr_own_d, rd_own_q, rd_own_d;
  logic wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [SW-1:0] starve_q, starve_d;
  logic wr_edge, rd_edge, wr_done, rd_done, wr_wrap, rd_wrap;
  logic idle, wr_cand, rd_cand;
  gnt_e gnt;
  function automatic logic [ADDR_W-1:0] rgn(logic ring, logic [ADDR_W-1:0] a);
    return ring ? a & OFF_MASK : a;
  endfunction
  // a burst only counts as done while we own it; loads and reset disown bursts in flight
  assign wr_edge = wr_load & ~wr_load_q;
  assign rd_edge = rd_load & ~rd_load_q;
  assign wr_done = wr_own_q & wr_ack_q & ~bus.sdram_wr_ack;
  assign rd_done = rd_own_q & rd_ack_q & ~bus.sdram_rd_ack;
  assign wr_wrap = rgn(ring_en, wr_off_q) >= rgn(ring_en, wr_max_addr) - ADDR_W'(wr_length);
  assign rd_wrap = rgn(ring_en, rd_off_q) >= rgn(ring_en, rd_max_addr) - ADDR_W'(rd_length);
  assign wr_off_d = wr_edge ? rgn(ring_en, wr_min_addr) : !wr_done ? wr_off_q :
                    wr_wrap ? rgn(ring_en, wr_min_addr) : rgn(ring_en, wr_off_q) + ADDR_W'(wr_length);
  assign rd_off_d = rd_edge ? rgn(ring_en, rd_min_addr) : !rd_done ? rd_off_q :
                    rd_wrap ? rgn(ring_en, rd_min_addr) : rgn(ring_en, rd_off_q) + ADDR_W'(rd_length);
  always_comb begin
    idle = ~(wr_req_q | rd_req_q | bus.sdram_wr_ack | bus.sdram_rd_ack | wr_done | rd_done);
    wr_cand = wrf_use >= wr_length;
    rd_cand = read_valid & (rdf_use < rd_length);
    gnt = ~(init_done & idle) ? GNT_NONE :
          wr_cand & ~(rd_cand & starve_q == SW'(STARVE_MAX)) ? GNT_WR :
          rd_cand ? GNT_RD : GNT_NONE;
    starve_d = ~rd_cand | gnt == GNT_RD ? '0 : gnt == GNT_WR ? starve_q + SW'(1) : starve_q;
    wr_req_d = init_done & (gnt == GNT_WR | wr_req_q & ~bus.sdram_wr_ack);
    rd_req_d = init_done & (gnt == GNT_RD | rd_req_q & ~bus.sdram_rd_ack);
    wr_own_d = wr_edge ? 1'b0 : gnt == GNT_WR ? 1'b1 : wr_done ? 1'b0 : wr_own_q;
    rd_own_d = rd_edge ? 1'b0 : gnt == GNT_RD ? 1'b1 : rd_done ? 1'b0 : rd_own_q;
  end
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wr_off_q <= '0;
      rd_off_q <= '0;
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      wr_load_q <= 1'b0;
      rd_load_q <= 1'b0;
      wr_own_q <= 1'b0;
      rd_own_q <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      starve_q <= '0;
    end else begin
      wr_off_q <= wr_off_d;
      rd_off_q <= rd_off_d;
      wr_ack_q <= bus.sdram_wr_ack;
      rd_ack_q <= bus.sdram_rd_ack;
      wr_load_q <= wr_load;
      rd_load_q <= rd_load;
      wr_own_q <= wr_own_d;
      rd_own_q <= rd_own_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      starve_q <= starve_d;
    end
  end
  sdram_buf_ring #(.NUM_BUF(NUM_BUF)) u_ring (
    .clk(clk_ref),
    .rst(rst),
    .wr_load_i(wr_edge),
    .rd_load_i(rd_edge),
    .wr_cmp_i(ring_en & wr_done & wr_wrap),
    .rd_cmp_i(ring_en & rd_done & rd_wrap),
    .wr_buf_o(wr_buf_idx),
    .rd_buf_o(rd_buf_idx),
    .frame_drop_o(frame_drop),
    .frame_repeat_o(frame_repeat)
  );
  assign bus.sdram_wr_req = wr_req_q & init_done;
  assign bus.sdram_rd_req = rd_req_q & init_done;
  assign bus.sdram_wr_addr = ring_en ? (ADDR_W'(wr_buf_idx) << BUF_SHIFT) | (wr_off_q & OFF_MASK) : wr_off_q;
  assign bus.sdram_rd_addr = ring_en ? (ADDR_W'(rd_buf_idx) << BUF_SHIFT) | (rd_off_q & OFF_MASK) : rd_off_q;
endmodule
